// File: rtl/gb_pkg.sv
// Shared constants and state encoding for the Game Boy LCD capture path.
// No ports; imported by the capture top and available to any other
// framebuffer-side block that needs the GB geometry.
package gb_pkg;

  localparam int GB_H_PIXELS         = 160;
  localparam int GB_V_PIXELS         = 144;
  localparam int GB_PIXEL_COUNT      = GB_H_PIXELS * GB_V_PIXELS;  // 23040
  localparam int FB_ADDR_WIDTH       = 15;
  localparam int GB_PIXEL_DATA_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_NOSIG      = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_WAIT_LINE  = 2'd2,
    ST_PIXELS     = 2'd3
  } state_t;

endpackage

// File: rtl/gb_capture_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised value.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   din         - asynchronous input bus (DATA_W bits)
//   dout        - synchronised value (last flop of the chain)
//   rise, fall  - per-bit edge flags, valid in the cycle dout changes
module sync_edge #(
  parameter int STAGES = 2,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] rise,
  output logic [DATA_W-1:0] fall
);

  logic [DATA_W-1:0] chain [STAGES];
  logic [DATA_W-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/gb_capture.sv
// Captures the asynchronous Game Boy LCD stream into the 25 MHz domain and
// turns it into single-cycle framebuffer writes.
// Ports:
//   clk, reset                     - 25 MHz clock, synchronous active-high reset
//   gb_dat, gb_hsync, gb_vsync,
//   gb_px_clk                      - asynchronous GB LCD pins
//   fb_wr_en/fb_wr_addr/fb_wr_data - one write per captured pixel
//   frame_done                     - pulse after the last pixel of a full frame
//   frame_short                    - pulse when VSYNC restarts an incomplete frame
//   gb_on                          - GB pixel clock is present
module gb_capture #(
  parameter int GB_H_PIXELS    = gb_pkg::GB_H_PIXELS,
  parameter int GB_V_PIXELS    = gb_pkg::GB_V_PIXELS,
  parameter int FB_ADDR_WIDTH  = gb_pkg::FB_ADDR_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int SIGNAL_TIMEOUT = 2500000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [gb_pkg::GB_PIXEL_DATA_WIDTH-1:0] gb_dat,
  input  logic                                   gb_hsync,
  input  logic                                   gb_vsync,
  input  logic                                   gb_px_clk,
  output logic                                   fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0]               fb_wr_addr,
  output logic [gb_pkg::GB_PIXEL_DATA_WIDTH-1:0] fb_wr_data,
  output logic                                   frame_done,
  output logic                                   frame_short,
  output logic                                   gb_on
);

  import gb_pkg::*;

  localparam int XW = (GB_H_PIXELS > 1) ? $clog2(GB_H_PIXELS) : 1;
  localparam int LW = (GB_V_PIXELS > 1) ? $clog2(GB_V_PIXELS) : 1;
  localparam int TW = $clog2(SIGNAL_TIMEOUT + 1);
  localparam int DW = GB_PIXEL_DATA_WIDTH;

  localparam logic [XW-1:0]            X_LAST = XW'(GB_H_PIXELS - 1);
  localparam logic [LW-1:0]            L_LAST = LW'(GB_V_PIXELS - 1);
  localparam logic [TW-1:0]            TO_MAX = TW'(SIGNAL_TIMEOUT);
  localparam logic [FB_ADDR_WIDTH-1:0] H_STEP = FB_ADDR_WIDTH'(GB_H_PIXELS);

  logic          px_fall, hs_rise, vs_rise;
  logic [DW-1:0] dat_sync;
  logic          px_sync_unused, px_rise_unused;
  logic          hs_sync_unused, hs_fall_unused;
  logic          vs_sync_unused, vs_fall_unused;
  logic [DW-1:0] dat_rise_unused, dat_fall_unused;

  // Data runs through an identical chain so it lines up with px_fall.
  sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(1)) u_px_sync (
    .clk(clk), .reset(reset), .din(gb_px_clk),
    .dout(px_sync_unused), .rise(px_rise_unused), .fall(px_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(1)) u_hs_sync (
    .clk(clk), .reset(reset), .din(gb_hsync),
    .dout(hs_sync_unused), .rise(hs_rise), .fall(hs_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(1)) u_vs_sync (
    .clk(clk), .reset(reset), .din(gb_vsync),
    .dout(vs_sync_unused), .rise(vs_rise), .fall(vs_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(DW)) u_dat_sync (
    .clk(clk), .reset(reset), .din(gb_dat),
    .dout(dat_sync), .rise(dat_rise_unused), .fall(dat_fall_unused)
  );

  state_t                   state, state_n;
  logic [XW-1:0]            x, x_n;
  logic [LW-1:0]            line, line_n;
  logic [FB_ADDR_WIDTH-1:0] line_base, base_n;
  logic [TW-1:0]            to_cnt, to_n;
  logic                     wr_en_n, done_n, short_n;
  logic [FB_ADDR_WIDTH-1:0] addr_n;
  logic [DW-1:0]            data_n;

  // Edge detection -> registered capture state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_NOSIG;
      x           <= '0;
      line        <= '0;
      line_base   <= '0;
      to_cnt      <= '0;
      fb_wr_en    <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      line        <= line_n;
      line_base   <= base_n;
      to_cnt      <= to_n;
      fb_wr_en    <= wr_en_n;
      fb_wr_addr  <= addr_n;
      fb_wr_data  <= data_n;
      frame_done  <= done_n;
      frame_short <= short_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    line_n  = line;
    base_n  = line_base;
    wr_en_n = 1'b0;
    addr_n  = fb_wr_addr;
    data_n  = fb_wr_data;
    done_n  = 1'b0;
    short_n = 1'b0;

    // Saturating watchdog, cleared by every pixel-clock falling edge.
    if (px_fall)                to_n = '0;
    else if (to_cnt == TO_MAX)  to_n = to_cnt;
    else                        to_n = to_cnt + TW'(1);

    if (state == ST_NOSIG) begin
      // Acquisition restarts the watchdog so a VSYNC-only wakeup gets a
      // full timeout window instead of bouncing straight back.
      if (px_fall || vs_rise) begin
        state_n = ST_WAIT_FRAME;
        to_n    = '0;
      end
    end else if (to_n == TO_MAX) begin
      state_n = ST_NOSIG;
    end else if (vs_rise) begin
      short_n = (state != ST_WAIT_FRAME);
      line_n  = '0;
      base_n  = '0;
      x_n     = '0;
      state_n = ST_WAIT_LINE;
    end else if (hs_rise) begin
      if (state == ST_WAIT_LINE) begin
        x_n     = '0;
        state_n = ST_PIXELS;
      end else if (state == ST_PIXELS) begin
        // Early HSYNC abandons the rest of the line.
        x_n = '0;
        if (line == L_LAST) begin
          state_n = ST_WAIT_FRAME;
        end else begin
          line_n = line + LW'(1);
          base_n = line_base + H_STEP;
        end
      end
    end else if (px_fall && state == ST_PIXELS) begin
      wr_en_n = 1'b1;
      addr_n  = line_base + FB_ADDR_WIDTH'(x);
      data_n  = dat_sync;
      if (x == X_LAST) begin
        x_n = '0;
        if (line == L_LAST) begin
          done_n  = 1'b1;
          state_n = ST_WAIT_FRAME;
        end else begin
          line_n  = line + LW'(1);
          base_n  = line_base + H_STEP;
          state_n = ST_WAIT_LINE;
        end
      end else begin
        x_n = x + XW'(1);
      end
    end
  end

  assign gb_on = (state != ST_NOSIG);

endmodule
